// File: rtl/alu_issue.sv
// RV32I issue stage: decodes one instruction plus its register operands into the ALU
// operand/op bundle and holds it in a single valid/ready register.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_aluc,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_is_br,
    output logic [2:0]       out_br_f3,
    output logic             out_illegal,
    output logic [CNT_W-1:0] out_issue_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]             w_opc;
    logic [4:0]             w_rd;
    logic [2:0]             w_f3;
    logic [6:0]             w_f7;
    logic [2:0]             w_op;
    logic signed [XLEN-1:0] w_imm_i;
    logic signed [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0]        w_imm_u;
    logic [XLEN-1:0]        w_shamt;

    assign w_opc   = in_inst[6:0];
    assign w_rd    = in_inst[11:7];
    assign w_f3    = in_inst[14:12];
    assign w_f7    = in_inst[31:25];
    // funct3 already matches the ALU op numbering except sltu, which shares slt's op
    assign w_op    = (w_f3 == 3'b011) ? 3'd2 : w_f3;
    assign w_imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_u = {in_inst[31:12], 12'b0};
    assign w_shamt = {{(XLEN-5){1'b0}}, in_inst[24:20]};

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [3:0]      w_aluc;
    logic            w_wen;
    logic            w_is_br;
    logic [2:0]      w_br_f3;
    logic            w_ill;

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_aluc  = 4'b0000;
        w_wen   = 1'b0;
        w_is_br = 1'b0;
        w_br_f3 = 3'b000;
        w_ill   = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_a    = in_rs1_data;
                w_b    = in_rs2_data;
                w_aluc = {(w_f3 == 3'b011) || (in_inst[30] && (w_f3 == 3'b000 || w_f3 == 3'b101)), w_op};
                w_wen  = 1'b1;
                w_ill  = !((w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                w_a    = in_rs1_data;
                w_b    = (w_f3 == 3'b001 || w_f3 == 3'b101) ? w_shamt : w_imm_i;
                w_aluc = {(w_f3 == 3'b011) || (w_f3 == 3'b101 && in_inst[30]), w_op};
                w_wen  = 1'b1;
                w_ill  = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                         (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
            end
            OPC_LUI: begin
                w_b    = w_imm_u;
                w_aluc = 4'b0011;
                w_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                w_a   = in_pc;
                w_b   = w_imm_u;
                w_wen = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_a   = in_pc;
                w_b   = XLEN'(4);
                w_wen = 1'b1;
            end
            OPC_LOAD: begin
                w_a   = in_rs1_data;
                w_b   = w_imm_i;
                w_wen = 1'b1;
            end
            OPC_STORE: begin
                w_a = in_rs1_data;
                w_b = w_imm_s;
            end
            OPC_BRANCH: begin
                w_a     = in_rs1_data;
                w_b     = in_rs2_data;
                w_is_br = 1'b1;
                w_br_f3 = w_f3;
                w_aluc  = w_f3[2] ? {w_f3[1], 3'b010} : 4'b1000;
                w_ill   = (w_f3 == 3'b010 || w_f3 == 3'b011);
            end
            default: w_ill = 1'b1;
        endcase
        // An undecodable instruction travels as an inert bundle so it can still be counted
        if (w_ill) begin
            w_a     = '0;
            w_b     = '0;
            w_aluc  = 4'b0000;
            w_wen   = 1'b0;
            w_is_br = 1'b0;
            w_br_f3 = 3'b000;
        end
    end

    logic             r_vld_p1;
    logic [XLEN-1:0]  r_a_p1;
    logic [XLEN-1:0]  r_b_p1;
    logic [3:0]       r_aluc_p1;
    logic [4:0]       r_rd_p1;
    logic             r_wen_p1;
    logic [XLEN-1:0]  r_pc_p1;
    logic             r_is_br_p1;
    logic [2:0]       r_br_f3_p1;
    logic             r_ill_p1;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_consume;

    assign in_ready  = !r_vld_p1 || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_consume = r_vld_p1 && out_ready;

    // Stage p0 -> p1: decoded bundle register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_cnt      <= '0;
            r_a_p1     <= '0;
            r_b_p1     <= '0;
            r_aluc_p1  <= 4'b0000;
            r_rd_p1    <= 5'd0;
            r_wen_p1   <= 1'b0;
            r_pc_p1    <= '0;
            r_is_br_p1 <= 1'b0;
            r_br_f3_p1 <= 3'b000;
            r_ill_p1   <= 1'b0;
        end else begin
            if (w_consume)
                r_cnt <= r_cnt + 1'b1;
            if (flush)
                r_vld_p1 <= 1'b0;
            else if (w_accept)
                r_vld_p1 <= 1'b1;
            else if (w_consume)
                r_vld_p1 <= 1'b0;
            if (w_accept) begin
                r_a_p1     <= w_a;
                r_b_p1     <= w_b;
                r_aluc_p1  <= w_aluc;
                r_rd_p1    <= w_rd;
                r_wen_p1   <= w_wen && (w_rd != 5'd0);
                r_pc_p1    <= in_pc;
                r_is_br_p1 <= w_is_br;
                r_br_f3_p1 <= w_br_f3;
                r_ill_p1   <= w_ill;
            end
        end
    end

    assign out_valid     = r_vld_p1;
    assign out_a         = r_a_p1;
    assign out_b         = r_b_p1;
    assign out_aluc      = r_aluc_p1;
    assign out_rd        = r_rd_p1;
    assign out_wen       = r_wen_p1;
    assign out_pc        = r_pc_p1;
    assign out_is_br     = r_is_br_p1;
    assign out_br_f3     = r_br_f3_p1;
    assign out_illegal   = r_ill_p1;
    assign out_issue_cnt = r_cnt;

endmodule
